// File: rtl/ddr5_phy_dqs_fsm.sv
// DDR5 PHY write-DQS sequencer: preamble, data, gap/interamble and postamble strobe generation.
// Optional DDR5_PHY_DQS_CRC_EN adds one extra DATA clock per burst to carry CRC UIs.
module ddr5_phy_dqs_fsm (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       wr_en_i,
  input  logic [1:0] pre_len_i,
  input  logic       burst_len_i,
  input  logic       post_len_i,
  input  logic [1:0] preamble_bits_i,
  input  logic [1:0] interamble_bits_i,
  output logic       preamble_load_o,
  output logic       preamble_valid_o,
  output logic       interamble_valid_o,
  output logic [2:0] interamble_shift_o,
  output logic       gap_burst_eight_o,
  output logic [1:0] dqs_o,
  output logic       dqs_oe_o,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PRE   = 3'd1,
    DATA  = 3'd2,
    GAP   = 3'd3,
    INTER = 3'd4,
    POST  = 3'd5
  } state_t;

`ifdef DDR5_PHY_DQS_CRC_EN
  localparam logic CRC_EXTRA = 1'b1;
`else
  localparam logic CRC_EXTRA = 1'b0;
`endif

  state_t     state_reg;
  logic [2:0] cnt_reg;
  logic [2:0] gap_cnt_reg;
  logic       bl_reg;
  // Set on every burst start; spends one extra DATA clock once cnt is exhausted.
  logic       crc_ext_reg;

  logic       preamble_load_reg;
  logic       preamble_valid_reg;
  logic       interamble_valid_reg;
  logic [2:0] interamble_shift_reg;
  logic       gap_burst_eight_reg;
  logic [1:0] dqs_reg;
  logic       dqs_oe_reg;

  function automatic logic [2:0] burst_last(input logic bl8);
    return bl8 ? 3'd3 : 3'd7;
  endfunction

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_reg            <= IDLE;
      cnt_reg              <= 3'd0;
      gap_cnt_reg          <= 3'd0;
      bl_reg               <= 1'b0;
      crc_ext_reg          <= 1'b0;
      preamble_load_reg    <= 1'b0;
      preamble_valid_reg   <= 1'b0;
      interamble_valid_reg <= 1'b0;
      interamble_shift_reg <= 3'd0;
      gap_burst_eight_reg  <= 1'b0;
      dqs_reg              <= 2'b00;
      dqs_oe_reg           <= 1'b0;
    end else begin
      // Outputs describe the state being entered; only IDLE releases the driver.
      preamble_load_reg    <= 1'b0;
      preamble_valid_reg   <= 1'b0;
      interamble_valid_reg <= 1'b0;
      interamble_shift_reg <= 3'd0;
      gap_burst_eight_reg  <= 1'b0;
      dqs_oe_reg           <= 1'b1;
      case (state_reg)
        IDLE: begin
          if (wr_en_i) begin
            state_reg          <= PRE;
            cnt_reg            <= {1'b0, pre_len_i};
            preamble_load_reg  <= 1'b1;
            preamble_valid_reg <= 1'b1;
            dqs_reg            <= preamble_bits_i;
          end else begin
            dqs_oe_reg <= 1'b0;
            dqs_reg    <= 2'b00;
          end
        end
        PRE: begin
          if (cnt_reg == 3'd0) begin
            state_reg   <= DATA;
            cnt_reg     <= burst_last(burst_len_i);
            bl_reg      <= burst_len_i;
            crc_ext_reg <= CRC_EXTRA;
            dqs_reg     <= 2'b10;
          end else begin
            cnt_reg            <= cnt_reg - 3'd1;
            preamble_valid_reg <= 1'b1;
            dqs_reg            <= preamble_bits_i;
          end
        end
        DATA: begin
          dqs_reg <= 2'b10;
          if (cnt_reg != 3'd0) begin
            cnt_reg <= cnt_reg - 3'd1;
          end else if (crc_ext_reg) begin
            crc_ext_reg <= 1'b0;
          end else if (wr_en_i) begin
            cnt_reg     <= burst_last(burst_len_i);
            bl_reg      <= burst_len_i;
            crc_ext_reg <= CRC_EXTRA;
          end else begin
            state_reg           <= GAP;
            gap_cnt_reg         <= 3'd1;
            gap_burst_eight_reg <= bl_reg;
            dqs_reg             <= 2'b00;
          end
        end
        GAP: begin
          if (wr_en_i && (gap_cnt_reg <= 3'd6)) begin
            state_reg            <= INTER;
            cnt_reg              <= gap_cnt_reg - 3'd1;
            interamble_shift_reg <= gap_cnt_reg;
            interamble_valid_reg <= 1'b1;
            dqs_reg              <= interamble_bits_i;
            gap_cnt_reg          <= 3'd0;
          end else if (gap_cnt_reg == 3'd7) begin
            state_reg   <= POST;
            cnt_reg     <= {2'b00, post_len_i};
            dqs_reg     <= 2'b01;
            gap_cnt_reg <= 3'd0;
          end else begin
            gap_cnt_reg <= gap_cnt_reg + 3'd1;
            dqs_reg     <= 2'b00;
          end
        end
        INTER: begin
          if (cnt_reg == 3'd0) begin
            state_reg   <= DATA;
            cnt_reg     <= burst_last(burst_len_i);
            bl_reg      <= burst_len_i;
            crc_ext_reg <= CRC_EXTRA;
            dqs_reg     <= 2'b10;
          end else begin
            cnt_reg              <= cnt_reg - 3'd1;
            interamble_valid_reg <= 1'b1;
            interamble_shift_reg <= interamble_shift_reg;
            dqs_reg              <= interamble_bits_i;
          end
        end
        POST: begin
          // Write requests are deliberately not looked at here; IDLE samples them again.
          if (cnt_reg == 3'd0) begin
            state_reg  <= IDLE;
            dqs_oe_reg <= 1'b0;
            dqs_reg    <= 2'b00;
          end else begin
            cnt_reg <= cnt_reg - 3'd1;
            dqs_reg <= 2'b01;
          end
        end
        default: begin
          state_reg   <= IDLE;
          cnt_reg     <= 3'd0;
          gap_cnt_reg <= 3'd0;
          dqs_oe_reg  <= 1'b0;
          dqs_reg     <= 2'b00;
        end
      endcase
    end
  end

  assign preamble_load_o    = preamble_load_reg;
  assign preamble_valid_o   = preamble_valid_reg;
  assign interamble_valid_o = interamble_valid_reg;
  assign interamble_shift_o = interamble_shift_reg;
  assign gap_burst_eight_o  = gap_burst_eight_reg;
  assign dqs_o              = dqs_reg;
  assign dqs_oe_o           = dqs_oe_reg;
  assign state_o            = state_reg;

endmodule

// File: tb/tb_ddr5_phy_dqs_fsm.sv
// Table-driven bench for ddr5_phy_dqs_fsm: per-cycle input/expected-output vectors plus reset corner cases.
module tb_ddr5_phy_dqs_fsm;

`ifdef DDR5_PHY_DQS_CRC_EN
  localparam int CRC_X = 1;
`else
  localparam int CRC_X = 0;
`endif

  localparam logic [2:0] S_IDLE = 3'd0, S_PRE = 3'd1, S_DATA = 3'd2,
                         S_GAP = 3'd3, S_INTER = 3'd4, S_POST = 3'd5;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       wr_en_i;
  logic [1:0] pre_len_i;
  logic       burst_len_i;
  logic       post_len_i;
  logic [1:0] preamble_bits_i;
  logic [1:0] interamble_bits_i;
  logic       preamble_load_o;
  logic       preamble_valid_o;
  logic       interamble_valid_o;
  logic [2:0] interamble_shift_o;
  logic       gap_burst_eight_o;
  logic [1:0] dqs_o;
  logic       dqs_oe_o;
  logic [2:0] state_o;

  ddr5_phy_dqs_fsm dut (
    .clk_i              (clk_i),
    .rst_i              (rst_i),
    .wr_en_i            (wr_en_i),
    .pre_len_i          (pre_len_i),
    .burst_len_i        (burst_len_i),
    .post_len_i         (post_len_i),
    .preamble_bits_i    (preamble_bits_i),
    .interamble_bits_i  (interamble_bits_i),
    .preamble_load_o    (preamble_load_o),
    .preamble_valid_o   (preamble_valid_o),
    .interamble_valid_o (interamble_valid_o),
    .interamble_shift_o (interamble_shift_o),
    .gap_burst_eight_o  (gap_burst_eight_o),
    .dqs_o              (dqs_o),
    .dqs_oe_o           (dqs_oe_o),
    .state_o            (state_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        wr;
    logic [1:0]  pl;
    logic        bl;
    logic        po;
    logic [1:0]  pb;
    logic [1:0]  ib;
    logic [12:0] exp;  // {state, dqs, oe, pload, pvalid, ivalid, ishift, g8}
  } vec_t;

  vec_t vecs[256];
  int   nvec   = 0;
  int   checks = 0;
  int   errors = 0;

  function automatic logic [12:0] pack(input logic [2:0] st, input logic [1:0] dqs, input logic oe,
                                       input logic pload, input logic pv, input logic iv,
                                       input logic [2:0] ish, input logic g8);
    return {st, dqs, oe, pload, pv, iv, ish, g8};
  endfunction

  task automatic push(input logic wr, input logic [1:0] pl, input logic bl, input logic po,
                      input logic [1:0] pb, input logic [1:0] ib, input logic [12:0] exp);
    vecs[nvec].wr = wr; vecs[nvec].pl = pl; vecs[nvec].bl = bl; vecs[nvec].po = po;
    vecs[nvec].pb = pb; vecs[nvec].ib = ib; vecs[nvec].exp = exp;
    nvec++;
  endtask

  function automatic logic [12:0] observed();
    return pack(state_o, dqs_o, dqs_oe_o, preamble_load_o, preamble_valid_o,
                interamble_valid_o, interamble_shift_o, gap_burst_eight_o);
  endfunction

  task automatic check(input string name, input logic [12:0] exp);
    logic [12:0] got;
    got = observed();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %04h required %04h (state %0d required %0d)", name, got, exp, got[12:10], exp[12:10]);
    end else begin
      $display("ok   %s: outputs %04h state %0d", name, got, got[12:10]);
    end
  endtask

  task automatic build_table();
    // Idle cycle after reset release
    push(0, 2'd1, 0, 0, 2'b00, 2'b00, pack(S_IDLE, 2'b00, 0, 0, 0, 0, 3'd0, 0));
    // Single BL16 burst, 2-clock preamble; pre_len change mid-PRE must be ignored
    push(1, 2'd1, 0, 0, 2'b01, 2'b11, pack(S_PRE, 2'b01, 1, 1, 1, 0, 3'd0, 0));
    push(0, 2'd3, 0, 0, 2'b11, 2'b11, pack(S_PRE, 2'b11, 1, 0, 1, 0, 3'd0, 0));
    for (int i = 0; i < 8 + CRC_X; i++)
      push(0, 2'd1, 0, 0, 2'b00, 2'b00, pack(S_DATA, 2'b10, 1, 0, 0, 0, 3'd0, 0));
    for (int i = 0; i < 7; i++)
      push(0, 2'd1, 0, 0, 2'b00, 2'b00, pack(S_GAP, 2'b00, 1, 0, 0, 0, 3'd0, 0));
    // gap_cnt at 7 goes to POST even with a request pending
    push(1, 2'd1, 0, 0, 2'b00, 2'b00, pack(S_POST, 2'b01, 1, 0, 0, 0, 3'd0, 0));
    push(0, 2'd1, 0, 0, 2'b00, 2'b00, pack(S_IDLE, 2'b00, 0, 0, 0, 0, 3'd0, 0));

    // Two gapless BL16 bursts, then a BL8 burst, interamble at gap 3, then a final BL16
    push(1, 2'd0, 0, 0, 2'b01, 2'b00, pack(S_PRE, 2'b01, 1, 1, 1, 0, 3'd0, 0));
    for (int i = 0; i < 2 * (8 + CRC_X); i++)
      push(1, 2'd0, 0, 0, 2'b00, 2'b00, pack(S_DATA, 2'b10, 1, 0, 0, 0, 3'd0, 0));
    push(1, 2'd0, 1, 0, 2'b00, 2'b00, pack(S_DATA, 2'b10, 1, 0, 0, 0, 3'd0, 0));
    for (int i = 0; i < 3 + CRC_X; i++)
      push(0, 2'd0, 1, 0, 2'b00, 2'b00, pack(S_DATA, 2'b10, 1, 0, 0, 0, 3'd0, 0));
    push(0, 2'd0, 1, 0, 2'b00, 2'b00, pack(S_GAP, 2'b00, 1, 0, 0, 0, 3'd0, 1));
    push(0, 2'd0, 1, 0, 2'b00, 2'b00, pack(S_GAP, 2'b00, 1, 0, 0, 0, 3'd0, 0));
    push(0, 2'd0, 1, 0, 2'b00, 2'b00, pack(S_GAP, 2'b00, 1, 0, 0, 0, 3'd0, 0));
    push(1, 2'd0, 0, 0, 2'b00, 2'b01, pack(S_INTER, 2'b01, 1, 0, 0, 1, 3'd3, 0));
    push(0, 2'd0, 0, 0, 2'b00, 2'b10, pack(S_INTER, 2'b10, 1, 0, 0, 1, 3'd3, 0));
    push(0, 2'd0, 0, 0, 2'b00, 2'b11, pack(S_INTER, 2'b11, 1, 0, 0, 1, 3'd3, 0));
    for (int i = 0; i < 8 + CRC_X; i++)
      push(0, 2'd0, 0, 0, 2'b00, 2'b00, pack(S_DATA, 2'b10, 1, 0, 0, 0, 3'd0, 0));
    for (int i = 0; i < 7; i++)
      push(0, 2'd0, 0, 1, 2'b00, 2'b00, pack(S_GAP, 2'b00, 1, 0, 0, 0, 3'd0, 0));
    // Two-clock postamble; post_len change and write requests during POST are ignored
    push(0, 2'd0, 0, 1, 2'b00, 2'b00, pack(S_POST, 2'b01, 1, 0, 0, 0, 3'd0, 0));
    push(1, 2'd0, 0, 0, 2'b00, 2'b00, pack(S_POST, 2'b01, 1, 0, 0, 0, 3'd0, 0));
    push(1, 2'd0, 0, 0, 2'b00, 2'b00, pack(S_IDLE, 2'b00, 0, 0, 0, 0, 3'd0, 0));
    push(0, 2'd0, 0, 0, 2'b00, 2'b00, pack(S_IDLE, 2'b00, 0, 0, 0, 0, 3'd0, 0));
  endtask

  initial begin
    rst_i = 1'b0; wr_en_i = 1'b0; pre_len_i = 2'd0; burst_len_i = 1'b0; post_len_i = 1'b0;
    preamble_bits_i = 2'b00; interamble_bits_i = 2'b00;
    build_table();
    @(posedge clk_i); @(posedge clk_i); #1;
    check("reset_state", pack(S_IDLE, 2'b00, 0, 0, 0, 0, 3'd0, 0));
    @(negedge clk_i); rst_i = 1'b1;

    for (int i = 0; i < nvec; i++) begin
      @(negedge clk_i);
      wr_en_i = vecs[i].wr; pre_len_i = vecs[i].pl; burst_len_i = vecs[i].bl;
      post_len_i = vecs[i].po; preamble_bits_i = vecs[i].pb; interamble_bits_i = vecs[i].ib;
      @(posedge clk_i); #1;
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Asynchronous reset in the middle of a burst
    @(negedge clk_i); wr_en_i = 1'b1; pre_len_i = 2'd0; burst_len_i = 1'b0; preamble_bits_i = 2'b01;
    @(posedge clk_i); #1;
    check("mid_pre", pack(S_PRE, 2'b01, 1, 1, 1, 0, 3'd0, 0));
    @(negedge clk_i); wr_en_i = 1'b0;
    for (int i = 0; i < 3; i++) @(posedge clk_i);
    #1;
    check("mid_data", pack(S_DATA, 2'b10, 1, 0, 0, 0, 3'd0, 0));
    @(negedge clk_i); rst_i = 1'b0;
    #1;
    check("async_reset_data", pack(S_IDLE, 2'b00, 0, 0, 0, 0, 3'd0, 0));
    @(posedge clk_i); #1;
    check("reset_held", pack(S_IDLE, 2'b00, 0, 0, 0, 0, 3'd0, 0));
    @(negedge clk_i); rst_i = 1'b1; wr_en_i = 1'b1; pre_len_i = 2'd2; preamble_bits_i = 2'b11;
    @(posedge clk_i); #1;
    check("first_wr_after_reset", pack(S_PRE, 2'b11, 1, 1, 1, 0, 3'd0, 0));
    @(negedge clk_i); wr_en_i = 1'b0; rst_i = 1'b0;
    #1;
    check("async_reset_pre", pack(S_IDLE, 2'b00, 0, 0, 0, 0, 3'd0, 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ddr5_phy_dqs_fsm.md
DDR5_PHY_DQS_FSM -- requirements
Module: ddr5_phy_dqs_fsm

Interface
REQ-001 The block SHALL provide input clk_i, 1 bit, system clock; all state updates occur on its rising edge.
REQ-002 The block SHALL provide input rst_i, 1 bit, asynchronous active-low reset.
REQ-003 The block SHALL provide input wr_en_i, 1 bit, write burst request; high means a burst is pending or continuing.
REQ-004 The block SHALL provide input pre_len_i, 2 bits, preamble length in clocks minus 1 (0 to 3 gives 1 to 4 clocks).
REQ-005 The block SHALL provide input burst_len_i, 1 bit, burst length select: 0 is BL16 (8 clocks), 1 is BL8 (4 clocks).
REQ-006 The block SHALL provide input post_len_i, 1 bit, postamble length select: 0 is 1 clock, 1 is 2 clocks.
REQ-007 The block SHALL provide input preamble_bits_i, 2 bits, preamble DQS pair from the shift stage.
REQ-008 The block SHALL provide input interamble_bits_i, 2 bits, interamble DQS pair from the shift stage.
REQ-009 The block SHALL provide output preamble_load_o, 1 bit, preamble register load strobe to the shift stage.
REQ-010 The block SHALL provide output preamble_valid_o, 1 bit, preamble shift enable.
REQ-011 The block SHALL provide output interamble_valid_o, 1 bit, interamble shift enable.
REQ-012 The block SHALL provide output interamble_shift_o, 3 bits, gap value driving interamble selection.
REQ-013 The block SHALL provide output gap_burst_eight_o, 1 bit, BL8 gap-correction pulse.
REQ-014 The block SHALL provide output dqs_o, 2 bits, DQS pair per clock; bit1 is the first UI.
REQ-015 The block SHALL provide output dqs_oe_o, 1 bit, DQS driver enable.
REQ-016 The block SHALL provide output state_o, 3 bits, current state encoding for debug.

Function
REQ-017 The block SHALL implement states IDLE=0, PRE=1, DATA=2, GAP=3, INTER=4 and POST=5, with all outputs registered.
REQ-018 In IDLE the block SHALL drive dqs_oe_o=0 and dqs_o=00; when wr_en_i=1 it SHALL pulse preamble_load_o for 1 cycle, load cnt with pre_len_i and transition to PRE.
REQ-019 In PRE the block SHALL drive preamble_valid_o=1, dqs_oe_o=1 and dqs_o=preamble_bits_i; when cnt reaches 0 it SHALL load cnt with the burst clocks minus 1 and transition to DATA.
REQ-020 In DATA the block SHALL drive dqs_o=10 every cycle with dqs_oe_o=1, decrementing cnt once per clock.
REQ-021 On the last DATA cycle with wr_en_i=1 the block SHALL reload cnt and remain in DATA (gapless back-to-back burst, no preamble).
REQ-022 On the last DATA cycle with wr_en_i=0 the block SHALL transition to GAP with gap_cnt=1, and SHALL pulse gap_burst_eight_o when burst_len_i=1.
REQ-023 In GAP the block SHALL drive dqs_o=00 with dqs_oe_o=1 and increment gap_cnt each cycle that wr_en_i=0, saturating at 7.
REQ-024 When wr_en_i=1 in GAP with gap_cnt at most 6, the block SHALL present interamble_shift_o=gap_cnt, load cnt with gap_cnt-1 and transition to INTER.
REQ-025 When gap_cnt reaches 7 in GAP, the block SHALL transition to POST with cnt=post_len_i.
REQ-026 In INTER the block SHALL drive interamble_valid_o=1, dqs_o=interamble_bits_i and dqs_oe_o=1; when cnt reaches 0 it SHALL transition to DATA.
REQ-027 In POST the block SHALL drive dqs_o=01 with dqs_oe_o=1; when cnt reaches 0 it SHALL transition to IDLE.
REQ-028 A wr_en_i pulse arriving during POST SHALL be ignored; it is sampled again in IDLE.
REQ-029 The cnt counter SHALL be 3 bits; the gap_cnt counter SHALL be 3 bits and SHALL never wrap.
REQ-030 All burst, preamble and postamble lengths SHALL be sampled on state entry; changes mid-state SHALL have no effect.

Reset
REQ-031 On rst_i=0 the block SHALL immediately enter IDLE, clear cnt and gap_cnt, and force every output to 0, including mid-burst.
REQ-032 After rst_i deasserts, the first wr_en_i=1 SHALL be handled per REQ-018 on the next edge.

Configuration
REQ-033 When DDR5_PHY_DQS_CRC_EN is defined, each DATA burst SHALL be extended by 1 clock (BL16 gives 9 clocks, BL8 gives 5 clocks) to carry CRC UIs.
REQ-034 When DDR5_PHY_DQS_CRC_EN is undefined, DATA bursts SHALL be exactly 8 clocks (BL16) or 4 clocks (BL8).

Verification
REQ-035 Reset, then wr_en_i=1 for 1 cycle with pre_len_i=1, BL16, post_len_i=0 -> preamble_load_o pulses once; 2 PRE cycles; 8 DATA cycles with dqs_o=10; GAP counts 1 to 7; 1 POST cycle with dqs_o=01; then IDLE with dqs_oe_o=0.
REQ-036 wr_en_i held high across two BL16 bursts -> 16 consecutive DATA cycles, no PRE or GAP between them.
REQ-037 wr_en_i reasserted at gap_cnt=3 -> interamble_shift_o=3, 3 INTER cycles with interamble_valid_o=1, then DATA.
REQ-038 BL8 burst ending with wr_en_i=0 -> gap_burst_eight_o high for exactly 1 cycle, coincident with the GAP entry edge.
REQ-039 rst_i asserted during DATA -> all outputs 0 within the same cycle, state_o=0.
REQ-040 With DDR5_PHY_DQS_CRC_EN defined, BL8 burst -> exactly 5 DATA cycles.
